// File: rtl/fpu_pkg.sv
// Shared types for the fpu request front-end: opcodes, control states and
// the request/result words carried through the FIFOs.
package fpu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    fpu_op_t     op;
  } fpu_req_t;

  typedef struct packed {
    logic [31:0] data;
    fpu_op_t     op;
  } fpu_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push while full is accepted
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count  = wrPtr - rdPtr;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Request front-end for the fixed-latency fpu: input FIFO, credit-checked
// issue, in-flight valid/opcode pipeline and result FIFO.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned FPU_LATENCY = 3,
  parameter int unsigned IN_DEPTH    = 4,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_opcode,
  input  logic [31:0] fpu_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_op,
  output logic        busy
);

  localparam int unsigned CW = $clog2(OUT_DEPTH + FPU_LATENCY + 1) + 1;

  state_t   state;
  state_t   stateNext;

  fpu_req_t inReq;
  fpu_req_t inHead;
  logic     inFull;
  logic     inEmpty;
  logic [$clog2(IN_DEPTH):0] inCount;
  logic     inPush;

  fpu_res_t outRes;
  fpu_res_t outHead;
  logic     outFull;
  logic     outEmpty;
  logic [$clog2(OUT_DEPTH):0] outCount;
  logic     outPush;
  logic     outPop;

  logic [FPU_LATENCY-1:0] pipeValid;
  fpu_op_t                pipeOp [FPU_LATENCY];
  logic                   pipeEmpty;
  logic [CW-1:0]          inflight;
  logic                   issue;

  assign inReq    = '{a: in_a, b: in_b, op: fpu_op_t'(in_op)};
  assign in_ready = !reset && !inFull && (state != DRAIN);
  assign inPush   = in_valid && in_ready;

  assign pipeEmpty = !(|pipeValid);
  assign outPush   = pipeValid[FPU_LATENCY-1];
  assign outRes    = '{data: fpu_o, op: pipeOp[FPU_LATENCY-1]};
  assign out_valid = !outEmpty;
  assign outPop    = out_ready && out_valid;
  assign out_data  = outEmpty ? '0 : outHead.data;
  assign out_op    = outEmpty ? '0 : outHead.op;
  assign busy      = (state != IDLE);

  sync_fifo #(
    .WIDTH($bits(fpu_req_t)),
    .DEPTH(IN_DEPTH)
  ) inFifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (inPush),
    .pop   (issue),
    .din   (inReq),
    .dout  (inHead),
    .full  (inFull),
    .empty (inEmpty),
    .count (inCount)
  );

  sync_fifo #(
    .WIDTH($bits(fpu_res_t)),
    .DEPTH(OUT_DEPTH)
  ) outFifo (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (outPush),
    .pop   (outPop),
    .din   (outRes),
    .dout  (outHead),
    .full  (outFull),
    .empty (outEmpty),
    .count (outCount)
  );

  // Credit counts every in-flight op plus registered output occupancy, so a
  // result leaving the pipeline always finds a free output slot.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < FPU_LATENCY; i++) begin
      inflight = inflight + CW'(pipeValid[i]);
    end
    issue = !inEmpty && (state == ACTIVE) && !flush &&
            ((CW'(outCount) + inflight) < CW'(OUT_DEPTH));
  end

  // A push landing in the same cycle keeps ACTIVE, otherwise the entry
  // would sit in the FIFO with the FSM parked in IDLE.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (inPush) stateNext = ACTIVE;
      ACTIVE:  if (inEmpty && pipeEmpty && !inPush) stateNext = IDLE;
      DRAIN:   if (pipeEmpty) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = DRAIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pipeValid  <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= '0;
      for (int unsigned i = 0; i < FPU_LATENCY; i++) pipeOp[i] <= ADD;
    end else begin
      state        <= stateNext;
      pipeValid[0] <= issue;
      pipeOp[0]    <= inHead.op;
      for (int unsigned i = 1; i < FPU_LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeOp[i]    <= pipeOp[i-1];
      end
      if (issue) begin
        fpu_a      <= inHead.a;
        fpu_b      <= inHead.b;
        fpu_opcode <= inHead.op;
      end
    end
  end

  aOutNoOverflow: assert property (@(posedge clk) disable iff (reset)
    outPush |-> (!outFull || outPop));
  aInCountRange: assert property (@(posedge clk) disable iff (reset)
    32'(inCount) <= IN_DEPTH);

endmodule
